// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry, widths and write-word type
package fb_pkg;

  localparam int FB_ADDR_W      = 17;
  localparam int FB_PIX_W       = 2;
  localparam int FB_WIDTH       = 320;
  localparam int FB_HEIGHT      = 240;
  localparam int FB_PIXELS      = FB_WIDTH * FB_HEIGHT;
  // vga_controller prefetches this many pixels ahead of the beam
  localparam int VGA_RD_LATENCY = 3;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_PIX_W-1:0]  data;
  } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous write-word FIFO with wrap-bit pointers
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          vga_clk_25,
  input  logic          reset_n,
  input  logic          push,
  input  fb_wr_t        din,
  input  logic          pop,
  output fb_wr_t        dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  fb_wr_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge vga_clk_25) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer arbiter, VGA reads over buffered writes
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int STALL_W    = 16,
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 vga_clk_25,
  input  logic                 reset_n,
  input  logic                 vga_active,
  input  logic [FB_ADDR_W-1:0] vga_addr,
  output logic [FB_PIX_W-1:0]  vga_dout,
  output logic                 vga_dout_valid,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [FB_PIX_W-1:0]  wr_data,
  output logic [FB_ADDR_W-1:0] ram_addr,
  output logic                 ram_we,
  output logic [FB_PIX_W-1:0]  ram_wdata,
  input  logic [FB_PIX_W-1:0]  ram_rdata,
  output logic [LW-1:0]        fifo_level,
  output logic [STALL_W-1:0]   stall_count,
  input  logic                 stat_clear
);

  fb_wr_t       head;
  fb_wr_t       push_word;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic [LW-1:0] next_level;
  logic [1:0]   rd_pipe;

  assign push_word = '{addr: wr_addr, data: wr_data};
  assign push      = wr_valid && wr_ready && !fifo_full;
  assign pop       = !vga_active && !fifo_empty;
  assign next_level = fifo_level + LW'(push) - LW'(pop);

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .vga_clk_25 (vga_clk_25),
    .reset_n    (reset_n),
    .push       (push),
    .din        (push_word),
    .pop        (pop),
    .dout       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  // One RAM access per cycle; ram_addr/ram_wdata hold when idle
  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else if (vga_active) begin
      ram_we   <= 1'b0;
      ram_addr <= vga_addr;
    end else if (!fifo_empty) begin
      ram_we    <= 1'b1;
      ram_addr  <= head.addr;
      ram_wdata <= head.data;
    end else begin
      ram_we <= 1'b0;
    end
  end

  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      rd_pipe        <= '0;
      vga_dout       <= '0;
      vga_dout_valid <= 1'b0;
    end else begin
      rd_pipe <= {rd_pipe[0], vga_active};
      if (rd_pipe[1]) begin
        vga_dout       <= ram_rdata;
        vga_dout_valid <= 1'b1;
      end else begin
        vga_dout_valid <= 1'b0;
      end
    end
  end

  // Ready is registered from the next occupancy so pop never reaches it combinationally
  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      wr_ready    <= 1'b0;
      stall_count <= '0;
    end else begin
      wr_ready <= (next_level < LW'(FIFO_DEPTH));
      if (stat_clear)
        stall_count <= '0;
      else if (wr_valid && !wr_ready && (stall_count != {STALL_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - self-checking bench for fb_arbiter
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int DEPTH = 8;
  localparam int SW    = 4;
  localparam int LW    = 4;

  logic                 vga_clk_25 = 1'b0;
  logic                 reset_n    = 1'b0;
  logic                 vga_active = 1'b0;
  logic [FB_ADDR_W-1:0] vga_addr   = '0;
  logic [FB_PIX_W-1:0]  vga_dout;
  logic                 vga_dout_valid;
  logic                 wr_valid   = 1'b0;
  logic                 wr_ready;
  logic [FB_ADDR_W-1:0] wr_addr    = '0;
  logic [FB_PIX_W-1:0]  wr_data    = '0;
  logic [FB_ADDR_W-1:0] ram_addr;
  logic                 ram_we;
  logic [FB_PIX_W-1:0]  ram_wdata;
  logic [FB_PIX_W-1:0]  ram_rdata  = '0;
  logic [LW-1:0]        fifo_level;
  logic [SW-1:0]        stall_count;
  logic                 stat_clear = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_acc  = 0;

  logic [FB_PIX_W-1:0] mem [0:131071];
  fb_wr_t              wq[$];
  logic [FB_PIX_W-1:0] rq[$];

  typedef struct {
    logic                 va;
    logic [FB_ADDR_W-1:0] vaddr;
    logic                 wv;
    logic [FB_ADDR_W-1:0] waddr;
    logic [FB_PIX_W-1:0]  wdata;
    logic                 clr;
    logic                 e_ready;
    logic [LW-1:0]        e_level;
    logic [SW-1:0]        e_stall;
    logic                 e_we;
  } vec_t;

  vec_t tbl [11];

  fb_arbiter #(.FIFO_DEPTH(DEPTH), .STALL_W(SW)) dut (
    .vga_clk_25     (vga_clk_25),
    .reset_n        (reset_n),
    .vga_active     (vga_active),
    .vga_addr       (vga_addr),
    .vga_dout       (vga_dout),
    .vga_dout_valid (vga_dout_valid),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .fifo_level     (fifo_level),
    .stall_count    (stall_count),
    .stat_clear     (stat_clear)
  );

  always #20 vga_clk_25 = ~vga_clk_25;

  function automatic logic [FB_PIX_W-1:0] pix_of(input logic [FB_ADDR_W-1:0] a);
    return a[4:3];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk_25);
    #1;
  endtask

  // Synchronous single-port RAM model
  always @(posedge vga_clk_25) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // Expectations are queued when the stimulus is accepted
  always @(posedge vga_clk_25) begin
    if (reset_n) begin
      if (wr_valid && wr_ready) begin
        wq.push_back('{addr: wr_addr, data: wr_data});
        n_acc++;
      end
      if (vga_active) rq.push_back(pix_of(vga_addr));
    end
  end

  always @(negedge vga_clk_25) begin
    fb_wr_t w;
    logic [FB_PIX_W-1:0] p;
    if (ram_we) begin
      if (wq.size() == 0) chk("ram_we_unexpected", 32'(ram_addr), 32'h1ffff);
      else begin
        w = wq.pop_front();
        chk("ram_write_word", 32'({ram_addr, ram_wdata}), 32'({w.addr, w.data}));
      end
    end
    if (vga_dout_valid) begin
      if (rq.size() == 0) chk("dout_valid_unexpected", 32'(vga_dout_valid), 32'd0);
      else begin
        p = rq.pop_front();
        chk("vga_dout", 32'(vga_dout), 32'(p));
      end
    end
    if (!reset_n) begin
      wq.delete();
      rq.delete();
    end
  end

  initial begin
    int acc0;
    int we_cnt;
    for (int i = 0; i < 131072; i++) mem[i] = pix_of(17'(i));

    tbl[0]  = '{1'b0, 17'h00000, 1'b0, 17'h00000, 2'd0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 17'h00000, 1'b1, 17'h12C00, 2'd1, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 17'h00000, 1'b1, 17'h00100, 2'd2, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1};
    tbl[3]  = '{1'b0, 17'h00000, 1'b0, 17'h00000, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1};
    tbl[4]  = '{1'b0, 17'h00000, 1'b0, 17'h00000, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0};
    tbl[5]  = '{1'b1, 17'h00018, 1'b1, 17'h00200, 2'd3, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0};
    tbl[6]  = '{1'b1, 17'h00008, 1'b1, 17'h00201, 2'd0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0};
    tbl[7]  = '{1'b0, 17'h00000, 1'b1, 17'h00202, 2'd1, 1'b0, 1'b1, 4'd2, 4'd0, 1'b1};
    tbl[8]  = '{1'b0, 17'h00000, 1'b0, 17'h00000, 2'd0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1};
    tbl[9]  = '{1'b0, 17'h00000, 1'b0, 17'h00000, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1};
    tbl[10] = '{1'b0, 17'h00000, 1'b0, 17'h00000, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0};

    // Reset held with a writer pushing
    wr_valid = 1'b1;
    wr_addr  = 17'h1F000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("reset_outputs", 32'({vga_dout, vga_dout_valid, ram_addr, ram_we, ram_wdata,
                               wr_ready, fifo_level, stall_count}), 32'd0);
    end
    reset_n  = 1'b1;
    wr_valid = 1'b0;
    step();
    chk("ready_after_reset", 32'(wr_ready), 32'd1);
    chk("level_after_reset", 32'(fifo_level), 32'd0);

    // Read latency
    vga_active = 1'b1;
    vga_addr   = 17'h00010;
    step();
    vga_active = 1'b0;
    chk("read_ram_addr", 32'(ram_addr), 32'h10);
    for (int k = 1; k <= 3; k++) begin
      chk("read_no_we", 32'(ram_we), 32'd0);
      chk("read_valid_timing", 32'(vga_dout_valid), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk("read_dout", 32'(vga_dout), 32'd2);
      if (k < 3) step();
    end

    // Table: idle write, push+pop overlap, reads interleaved with writes
    for (int r = 0; r < 11; r++) begin
      vga_active = tbl[r].va;
      vga_addr   = tbl[r].vaddr;
      wr_valid   = tbl[r].wv;
      wr_addr    = tbl[r].waddr;
      wr_data    = tbl[r].wdata;
      stat_clear = tbl[r].clr;
      step();
      chk($sformatf("tbl%0d_ready", r), 32'(wr_ready), 32'(tbl[r].e_ready));
      chk($sformatf("tbl%0d_level", r), 32'(fifo_level), 32'(tbl[r].e_level));
      chk($sformatf("tbl%0d_stall", r), 32'(stall_count), 32'(tbl[r].e_stall));
      chk($sformatf("tbl%0d_we", r), 32'(ram_we), 32'(tbl[r].e_we));
      if (r == 2) chk("idle_write_addr", 32'({ram_addr, ram_wdata}), 32'({17'h12C00, 2'd1}));
    end
    stat_clear = 1'b0;
    wr_valid   = 1'b0;

    // Sustained reads fill the FIFO and stall the writer
    acc0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      vga_active = 1'b1;
      vga_addr   = 17'h00400 + 17'(i);
      wr_valid   = 1'b1;
      wr_addr    = 17'h01000 + 17'(i);
      wr_data    = 2'(i);
      step();
    end
    chk("prio_accepted", 32'(n_acc - acc0), 32'd8);
    chk("prio_ready", 32'(wr_ready), 32'd0);
    chk("prio_level", 32'(fifo_level), 32'd8);
    chk("prio_stall", 32'(stall_count), 32'd12);
    vga_active = 1'b0;
    wr_valid   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_we", 32'(ram_we), 32'd1);
    end
    step();
    chk("drain_done_we", 32'(ram_we), 32'd0);
    chk("drain_done_level", 32'(fifo_level), 32'd0);
    chk("drain_done_ready", 32'(wr_ready), 32'd1);

    // Stall counter saturation and clear priority
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    chk("stall_cleared", 32'(stall_count), 32'd0);
    for (int i = 0; i < 28; i++) begin
      vga_active = 1'b1;
      vga_addr   = 17'h00500 + 17'(i);
      wr_valid   = 1'b1;
      wr_addr    = 17'h02000 + 17'(i);
      wr_data    = 2'(i + 1);
      step();
      if (i == 22) chk("stall_reach_max", 32'(stall_count), 32'd15);
    end
    chk("stall_saturated", 32'(stall_count), 32'd15);
    stat_clear = 1'b1;
    step();
    chk("stall_clear_wins", 32'(stall_count), 32'd0);
    stat_clear = 1'b0;
    step();
    chk("stall_after_clear", 32'(stall_count), 32'd1);
    vga_active = 1'b0;
    wr_valid   = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("sat_drain_level", 32'(fifo_level), 32'd0);

    // Mid-operation reset
    for (int i = 0; i < 5; i++) begin
      vga_active = 1'b1;
      vga_addr   = 17'h00600 + 17'(i);
      wr_valid   = 1'b1;
      wr_addr    = 17'h03000 + 17'(i);
      wr_data    = 2'(i);
      step();
    end
    wr_valid   = 1'b0;
    vga_active = 1'b0;
    chk("midrst_level5", 32'(fifo_level), 32'd5);
    step();
    chk("midrst_pop_we", 32'(ram_we), 32'd1);
    chk("midrst_level4", 32'(fifo_level), 32'd4);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_level0", 32'(fifo_level), 32'd0);
    chk("midrst_we0", 32'(ram_we), 32'd0);
    chk("midrst_valid0", 32'(vga_dout_valid), 32'd0);
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      we_cnt += int'(ram_we);
    end
    chk("midrst_no_we", 32'(we_cnt), 32'd0);
    chk("midrst_ready", 32'(wr_ready), 32'd1);

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port framebuffer arbiter between the VGA scan-out read path and a pixel writer, such as the capture pipeline. VGA reads have absolute priority while the display is in the framebuffer region. Writes are buffered in a small synchronous FIFO and drained into the RAM during any cycle without a read. The block sits between `vga_controller`, the writer and the framebuffer RAM, all in the `vga_clk_25` domain.

## Interface
- `FIFO_DEPTH`, default 8: write FIFO entries; power of 2, minimum 2.
- `STALL_W`, default 16: width of the write-stall counter.
- `vga_clk_25`  in  1  pixel clock, 25 MHz; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `vga_active`  in  1  VGA requests a read this cycle.
- `vga_addr`  in  17  VGA read address, 0..76799.
- `vga_dout`  out  2  read pixel, registered.
- `vga_dout_valid`  out  1  `vga_dout` updated this cycle.
- `wr_valid`  in  1  writer presents a pixel.
- `wr_ready`  out  1  FIFO can accept, registered.
- `wr_addr`  in  17  write address.
- `wr_data`  in  2  write pixel.
- `ram_addr`  out  17  RAM address, registered.
- `ram_we`  out  1  RAM write enable, registered.
- `ram_wdata`  out  2  RAM write data, registered.
- `ram_rdata`  in  2  RAM read data, valid the cycle after RAM samples `ram_addr`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `stall_count`  out  STALL_W  saturating count of `wr_valid && !wr_ready` cycles.
- `stat_clear`  in  1  clears `stall_count`.

## Operation
- Write push: the FIFO accepts a word on any edge where `wr_valid && wr_ready`; the word is `{wr_addr, wr_data}`.
- Grant is decided every edge, in priority order:
  - `vga_active`=1: register a read. `ram_we`<=0, `ram_addr`<=`vga_addr`.
  - Otherwise, FIFO non-empty: pop the head. `ram_we`<=1, `ram_addr`/`ram_wdata`<=head.
  - Otherwise: `ram_we`<=0; `ram_addr` and `ram_wdata` hold.
- Read pipeline: a 2-bit shift register `rd_pipe` shifts in `vga_active`. When `rd_pipe[1]`=1, `vga_dout`<=`ram_rdata` and `vga_dout_valid`<=1. Otherwise `vga_dout` holds and `vga_dout_valid`<=0.
- `wr_ready` next value is (next occupancy < `FIFO_DEPTH`). There is no combinational path from pop to ready.
- `stall_count` increments on each cycle where `wr_valid && !wr_ready`.
  - Saturates at all-ones.
  - `stat_clear` wins over a simultaneous increment; the result is 0.
- No read-after-write forwarding. A read of an address with a pending FIFO write returns the old RAM contents. This is accepted: the tear is at most one frame.
- No address range check. Out-of-range addresses pass through unchanged.

## Timing
- Reset, checked on each edge with `reset_n`=0:
  - `vga_dout`=0, `vga_dout_valid`=0.
  - `ram_addr`=0, `ram_we`=0, `ram_wdata`=0.
  - `wr_ready`=0, `fifo_level`=0, `stall_count`=0.
  - FIFO emptied and `rd_pipe` cleared.
- `wr_ready` rises on the first edge after `reset_n` goes high.
- Reset mid-operation:
  - Queued writes are discarded.
  - A write registered on the previous edge has already been presented to the RAM and completes.
  - In-flight reads are dropped; `vga_dout_valid` is not asserted for them.
- Read latency: `vga_addr` sampled at edge N, `ram_addr` valid after N, `ram_rdata` valid after N+1, `vga_dout`/`vga_dout_valid` after N+2. Three cycles from address presentation to registered pixel. `vga_controller` must prefetch 3 pixels ahead.
- Write latency: with FIFO empty and `vga_active`=0, a word pushed at edge N is popped at N+1. `ram_we`=1 is seen by the RAM at N+2.
- Push and pop on the same edge: occupancy is unchanged.
- Full FIFO: a pop at edge N re-asserts `wr_ready` after N.
- Empty FIFO: no push-to-RAM bypass.
- Sustained `vga_active`: the FIFO fills. After `FIFO_DEPTH` accepted words `wr_ready`=0 and the stall counter runs. Draining resumes on the first cycle with `vga_active`=0.
- Throughput: 1 RAM access per cycle, no turnaround cycles between read and write.

## Structure
- Package `fb_pkg`:
  - `FB_ADDR_W`=17, `FB_PIX_W`=2.
  - `FB_WIDTH`=320, `FB_HEIGHT`=240, `FB_PIXELS`=76800.
  - Typedef `fb_wr_t` = {addr, data}.
  - `VGA_RD_LATENCY`=3, shared with `vga_controller` for prefetch.
- Sub-module `fb_wr_fifo`: synchronous FIFO of `fb_wr_t` with push, pop, full, empty and level. It uses wrap-around pointers with one extra MSB for full/empty.
- Grant logic, read pipeline and stall counter live in `fb_arbiter`.

## Test plan
- Reset: hold `reset_n`=0 for 4 cycles with `wr_valid`=1 -> all outputs 0 throughout. `wr_ready`=1 one cycle after release.
- Read latency: `vga_active`=1, `vga_addr`=0x00010; RAM model returns 2'b10 -> `vga_dout`=2'b10 with `vga_dout_valid`=1 exactly 3 edges later. No `ram_we` asserted.
- Idle write: `vga_active`=0, push (0x12C00, 2'b01) -> `ram_we`=1, `ram_addr`=0x12C00, `ram_wdata`=2'b01 two edges after the push. `fifo_level` returns to 0.
- Priority and backpressure: `vga_active`=1 for 20 cycles, `wr_valid`=1 constantly.
  - 8 words accepted, then `wr_ready`=0 and `stall_count`=12.
  - On `vga_active`=0, 8 consecutive `ram_we` pulses with addresses in push order.
- Stall counter: with `STALL_W`=4, stall for 20 cycles -> `stall_count` stays at 15. Pulse `stat_clear` during a stall -> 0 on the next edge.
- Mid-operation reset: 5 words queued, then `reset_n`=0 for 1 cycle -> `fifo_level`=0. No further `ram_we` after the edge following reset.
